// File: rtl/page_q_pkg.sv
// Shared defaults and sizing helpers for the page stream queue bank.
package page_q_pkg;

  localparam int unsigned DEF_W         = 9;
  localparam int unsigned DEF_BUF_DEPTH = 15;
  localparam int unsigned DEF_DEPTH     = DEF_BUF_DEPTH + 1;
  localparam int unsigned DEF_SLACK     = 0;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // The head register holds one token, the circular buffer the rest.
  function automatic int unsigned calc_buf_depth(input int unsigned depth);
    return depth - 1;
  endfunction

  function automatic int unsigned calc_ptr_w(input int unsigned buf_depth);
    return (buf_depth > 1) ? $clog2(buf_depth) : 1;
  endfunction

endpackage

// File: rtl/page_queue_ch.sv
// One stream queue channel: registered head, circular buffer, occupancy and
// sticky overflow status.
module page_queue_ch
  import page_q_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SLACK = DEF_SLACK,
  parameter int unsigned CW    = calc_cw(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  qin_d,
  input  logic          qin_e,
  input  logic          qin_v,
  output logic          qin_b,
  output logic [W-1:0]  qout_d,
  output logic          qout_e,
  output logic          qout_v,
  input  logic          qout_b,
  output logic [CW-1:0] occ,
  output logic          ovf
);

  localparam int unsigned BD  = calc_buf_depth(DEPTH);
  localparam int unsigned PW  = calc_ptr_w(BD);
  localparam int unsigned THR = DEPTH - SLACK;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } token_t;

  token_t          mem [BD];
  token_t          head;
  logic            head_v;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            ovf_q;

  logic pop, full, push, drop, buf_empty, refill, load_buf, bypass, wr;
  token_t in_tok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and head-refill decisions, all from registered state plus inputs.
  always_comb begin
    in_tok    = '{d: qin_d, e: qin_e};
    pop       = head_v & ~qout_b;
    full      = (cnt == CW'(DEPTH));
    push      = qin_v & (~full | pop);
    drop      = qin_v & ~push;
    buf_empty = (cnt == CW'(head_v));
    refill    = ~head_v | pop;
    load_buf  = refill & ~buf_empty;
    bypass    = refill & buf_empty & push;
    wr        = push & ~bypass;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head   <= '0;
      head_v <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load_buf) begin
        head   <= mem[rptr];
        head_v <= 1'b1;
        rptr   <= ptr_inc(rptr);
      end else if (bypass) begin
        head   <= in_tok;
        head_v <= 1'b1;
      end else if (refill) begin
        head_v <= 1'b0;
      end
      if (wr) wptr <= ptr_inc(wptr);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Buffer storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (wr && !reset) mem[wptr] <= in_tok;
  end

  assign qin_b  = reset | (cnt >= CW'(THR));
  assign qout_d = head.d;
  assign qout_e = head.e;
  assign qout_v = head_v;
  assign occ    = cnt;
  assign ovf    = ovf_q;

endmodule

// File: rtl/page_queue_bank.sv
// Bank of NCH independent stream queues between page logic and stream ports.
module page_queue_bank
  import page_q_pkg::*;
#(
  parameter int unsigned NCH   = 8,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned SLACK = DEF_SLACK,
  parameter int unsigned CW    = calc_cw(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*W-1:0]  qin_d,
  input  logic [NCH-1:0]    qin_e,
  input  logic [NCH-1:0]    qin_v,
  output logic [NCH-1:0]    qin_b,
  output logic [NCH*W-1:0]  qout_d,
  output logic [NCH-1:0]    qout_e,
  output logic [NCH-1:0]    qout_v,
  input  logic [NCH-1:0]    qout_b,
  output logic [NCH*CW-1:0] occ,
  output logic [NCH-1:0]    ovf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    page_queue_ch #(
      .W     (W),
      .DEPTH (DEPTH),
      .SLACK (SLACK),
      .CW    (CW)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .qin_d  (qin_d[i*W +: W]),
      .qin_e  (qin_e[i]),
      .qin_v  (qin_v[i]),
      .qin_b  (qin_b[i]),
      .qout_d (qout_d[i*W +: W]),
      .qout_e (qout_e[i]),
      .qout_v (qout_v[i]),
      .qout_b (qout_b[i]),
      .occ    (occ[i*CW +: CW]),
      .ovf    (ovf[i])
    );
  end

endmodule

// File: tb/tb_page_queue_bank.sv
// Directed self-checking bench for page_queue_bank (4 channels, DEPTH=16, SLACK=2).
module tb_page_queue_bank;

  localparam int unsigned NCH   = 4;
  localparam int unsigned W     = 9;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SLACK = 2;
  localparam int unsigned CW    = 5;

  logic              clock;
  logic              reset;
  logic [NCH*W-1:0]  qin_d;
  logic [NCH-1:0]    qin_e;
  logic [NCH-1:0]    qin_v;
  logic [NCH-1:0]    qin_b;
  logic [NCH*W-1:0]  qout_d;
  logic [NCH-1:0]    qout_e;
  logic [NCH-1:0]    qout_v;
  logic [NCH-1:0]    qout_b;
  logic [NCH*CW-1:0] occ;
  logic [NCH-1:0]    ovf;

  int checks = 0;
  int errors = 0;

  page_queue_bank #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH), .SLACK(SLACK), .CW(CW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .qin_d  (qin_d),
    .qin_e  (qin_e),
    .qin_v  (qin_v),
    .qin_b  (qin_b),
    .qout_d (qout_d),
    .qout_e (qout_e),
    .qout_v (qout_v),
    .qout_b (qout_b),
    .occ    (occ),
    .ovf    (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         b;
    logic         exp_v;
    logic [W-1:0] exp_d;
    logic [CW-1:0] exp_occ;
    logic         exp_qb;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [W-1:0] d,
                        input logic e, input logic b);
    qin_v[ch]        = v;
    qin_d[ch*W +: W] = d;
    qin_e[ch]        = e;
    qout_b[ch]       = b;
  endtask

  task automatic idle_all();
    qin_v  = '0;
    qin_d  = '0;
    qin_e  = '0;
    qout_b = '1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Fill channel 0, full-with-pop push, overflow, then drain.
    for (int k = 1; k <= 16; k++)
      vecs.push_back('{1'b1, W'(k - 1), 1'b1, 1'b1, W'(0), CW'(k), 1'(k >= 14), 1'b0});
    vecs.push_back('{1'b1, W'(9'h055), 1'b0, 1'b1, W'(1), CW'(16), 1'b1, 1'b0});
    vecs.push_back('{1'b1, W'(9'h0FF), 1'b1, 1'b1, W'(1), CW'(16), 1'b1, 1'b1});
    for (int j = 1; j <= 16; j++)
      vecs.push_back('{1'b0, W'(0), 1'b0, 1'(j < 16),
                       (j <= 14) ? W'(j + 1) : W'(9'h055),
                       CW'(16 - j), 1'((16 - j) >= 14), 1'b1});

    idle_all();
    reset = 1'b1;
    tick();
    check("rst_qin_b", 32'(qin_b), 32'hF);
    tick();
    reset = 1'b0;
    #1;
    check("rst_qout_v", 32'(qout_v), 0);
    check("rst_qout_d", 32'(qout_d), 0);
    check("rst_qout_e", 32'(qout_e), 0);
    check("rst_occ", 32'(occ), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_qin_b_release", 32'(qin_b), 0);

    // Single token into empty channel 0.
    set_ch(0, 1'b1, 9'h1A5, 1'b0, 1'b1);
    tick();
    set_ch(0, 1'b0, 9'h000, 1'b0, 1'b1);
    check("single_v", 32'(qout_v[0]), 1);
    check("single_d", 32'(qout_d[0 +: W]), 32'h1A5);
    check("single_occ", 32'(occ[0 +: CW]), 1);
    check("single_others_v", 32'(qout_v[NCH-1:1]), 0);
    tick();
    check("single_hold_d", 32'(qout_d[0 +: W]), 32'h1A5);
    set_ch(0, 1'b0, 9'h000, 1'b0, 1'b0);
    tick();
    check("single_pop_v", 32'(qout_v[0]), 0);
    check("single_pop_occ", 32'(occ[0 +: CW]), 0);
    idle_all();
    do_reset();

    foreach (vecs[i]) begin
      set_ch(0, vecs[i].v, vecs[i].d, 1'b0, vecs[i].b);
      tick();
      check($sformatf("vec%0d_v", i), 32'(qout_v[0]), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v)
        check($sformatf("vec%0d_d", i), 32'(qout_d[0 +: W]), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_occ", i), 32'(occ[0 +: CW]), 32'(vecs[i].exp_occ));
      check($sformatf("vec%0d_qin_b", i), 32'(qin_b[0]), 32'(vecs[i].exp_qb));
      check($sformatf("vec%0d_ovf", i), 32'(ovf[0]), 32'(vecs[i].exp_ovf));
    end
    idle_all();

    // Streaming on channel 1: one token per cycle, eos on the last.
    for (int i = 0; i < 100; i++) begin
      set_ch(1, 1'b1, W'(i), 1'(i == 99), 1'b0);
      tick();
      check($sformatf("stream%0d_v", i), 32'(qout_v[1]), 1);
      check($sformatf("stream%0d_d", i), 32'(qout_d[W +: W]), 32'(i));
      check($sformatf("stream%0d_e", i), 32'(qout_e[1]), 32'(i == 99));
      check($sformatf("stream%0d_occ", i), 32'(occ[CW +: CW]), 1);
    end
    set_ch(1, 1'b0, W'(0), 1'b0, 1'b0);
    tick();
    check("stream_end_v", 32'(qout_v[1]), 0);
    check("stream_end_occ", 32'(occ[CW +: CW]), 0);
    idle_all();

    // Mid-stream reset with channel 2 holding 7 tokens and channel 0 ovf set.
    for (int i = 0; i < 7; i++) begin
      set_ch(2, 1'b1, W'(i + 8'h40), 1'b0, 1'b1);
      tick();
    end
    set_ch(2, 1'b0, W'(0), 1'b0, 1'b1);
    check("midrst_pre_occ", 32'(occ[2*CW +: CW]), 7);
    check("midrst_pre_ovf0", 32'(ovf[0]), 1);
    reset = 1'b1;
    #1;
    check("midrst_qin_b", 32'(qin_b), 32'hF);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_v", 32'(qout_v), 0);
    check("midrst_occ", 32'(occ), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_qin_b_rel", 32'(qin_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/page_queue_bank.md
# page_queue_bank

Parametrised bank of NCH independent stream queues for page boundaries. Each queue carries a W-bit data token plus an end-of-stream flag, and uses the valid/back-pressure handshake. It replaces fixed eight-channel, 10-bit, 16-deep queue wrappers. New relative to those wrappers:
- programmable back-pressure slack
- per-channel occupancy and sticky overflow status

It sits between page logic and the page's non-input stream ports.

## Interface
Parameters:
- NCH, 8, number of independent channels
- W, 9, data bits per token, excluding the eos flag
- DEPTH, 16, token capacity per channel, including the output register; must be ≥ 2
- SLACK, 0, free slots reserved for in-flight tokens; must be < DEPTH
- CW, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- qin_d  in  NCH*W  input data; channel i occupies [i*W +: W]
- qin_e  in  NCH  input end-of-stream flag per channel
- qin_v  in  NCH  input valid per channel
- qin_b  out  NCH  back-pressure to the producer
- qout_d  out  NCH*W  output data
- qout_e  out  NCH  output eos flag
- qout_v  out  NCH  output valid
- qout_b  in  NCH  back-pressure from the consumer
- occ  out  NCH*CW  per-channel token count
- ovf  out  NCH  sticky overflow flag

## Operation
- Channels are fully independent; no shared arbitration.
- Push: on a clock edge where qin_v[i]=1 and channel i can accept, the token {d,e} is stored.
  - A channel can accept when occ<DEPTH, or when occ==DEPTH and a pop occurs in the same cycle.
- Producer rule: the producer stops within SLACK+1 cycles of qin_b rising.
- Pop: on a clock edge where qout_v[i]=1 and qout_b[i]=0, the head token leaves.
- qin_b[i] = (occ[i] ≥ DEPTH−SLACK). It is combinational from registered state only, never from qin_v or qout_b.
- Overflow: qin_v=1 when the channel cannot accept. The token is dropped, ovf[i] is set to 1 and stays set until reset, and occ is unchanged.
- Ordering is strict FIFO per channel. The eos flag travels with its token unmodified; the bank does not interpret it.
- Storage: one registered output stage (head) plus a (DEPTH−1)-entry circular buffer. Read and write pointers wrap modulo DEPTH−1.
- Head refill: the head is loaded from the buffer when the buffer is non-empty. If the buffer is empty, an incoming push goes straight to the head (bypass).
- occ counts the head plus buffer entries and is always in the range 0..DEPTH.

## Timing
- Reset values:
  - qout_v=0, qout_d=0, qout_e=0, occ=0, ovf=0
  - pointers = 0
  - qin_b forced to 1 while reset=1, and equal to (0 ≥ DEPTH−SLACK)=0 from the first cycle after reset.
- Reset mid-operation discards all stored tokens at that edge.
- Latency into an empty channel: a token pushed at edge t gives qout_v=1 with that token after edge t; it is visible in the cycle following t.
- Throughput: one push and one pop per channel per cycle, sustained. A simultaneous push and pop leaves occ unchanged.
- Full with simultaneous pop: the push is accepted, no ovf, and occ stays at DEPTH.
- Empty with simultaneous push: pop is impossible because qout_v=0. occ goes to 1.
- When the head pops and the buffer holds k ≥ 1 entries, the next token is valid in the head in the following cycle, so there are no bubbles.
- qout_d and qout_e hold their value while qout_v=1 and qout_b=1.
- After the last pop, qout_v drops to 0. qout_d/qout_e keep their last value and are don't-care.

## Structure
- Shared package page_q_pkg holds:
  - the token struct {logic [W-1:0] d; logic e;} (parametrised by typedef within the module)
  - the CW computation function
  - the localparam for buffer depth, DEPTH−1
- Sub-module: page_queue_ch, one channel holding head, buffer, pointers, occ, ovf and qin_b. page_queue_bank is a generate loop of NCH instances plus bus slicing.

## Test plan
- Reset then single token: push d=0x1A5, e=0 on channel 0 → qout_v[0]=1 and qout_d=0x1A5 one cycle later; occ[0]=1; other channels keep qout_v=0.
- Fill to capacity: DEPTH=16, SLACK=2, qout_b=1, push 16 tokens 0..15 → qin_b rises when occ reaches 14; occ=16; ovf=0.
- Overflow: with occ=16, push 0x0FF → ovf=1 and occ stays 16. Then drain 16 tokens → values 0..15 in order; 0x0FF is never output.
- Full plus simultaneous push/pop: occ=16, qout_b=0, push 0x055 → accepted, ovf=0, occ=16. 0x055 exits as the 16th subsequent pop.
- Streaming: qin_v=1 and qout_b=0 continuously for 100 tokens with eos on the last → one token per cycle out, 1-cycle latency. qout_e=1 only on token 99; occ stays at 1.
- Mid-stream reset: channel holding 7 tokens, reset=1 for one cycle → after reset, qout_v=0, occ=0, ovf=0. qin_b=1 during the reset cycle.
